// File: rtl/vend_pkg.sv
// Shared types and constants for the vending machine: dispenser states,
// product codes and the default price list also used by the upstream FSM.
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MOTOR  = 3'd1,
        DROP   = 3'd2,
        CHANGE = 3'd3,
        DONE   = 3'd4
    } state_t;

    typedef enum logic {
        PROD_A = 1'b0,
        PROD_B = 1'b1
    } prod_t;

    localparam int PRICE_A_DEF = 2;
    localparam int PRICE_B_DEF = 3;

    // Credit minus price, clamped at zero when the credit is short.
    function automatic logic [3:0] sub_sat(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return diff[4] ? 4'd0 : diff[3:0];
    endfunction

endpackage

// File: rtl/vend_dispenser_timer.sv
// Loadable down-counter; done is high in the last cycle of a loaded interval
// so the owner can act on the edge that ends it.
module cycle_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg == W'(1));

endmodule

// File: rtl/vend_dispenser.sv
// Dispense stage: runs the product motor, waits for the drop sensor, pays
// change (or a full refund on timeout) as unit pulses, then clears credit.
module vend_dispenser
    import vend_pkg::*;
#(
    parameter int PRICE_A      = PRICE_A_DEF,
    parameter int PRICE_B      = PRICE_B_DEF,
    parameter int MOTOR_CYCLES = 8,
    parameter int DROP_TIMEOUT = 32,
    parameter int GAP          = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       vendA,
    input  logic       vendB,
    input  logic [3:0] total,
    input  logic       caida,
    output logic       motorA,
    output logic       motorB,
    output logic       cambio_pulso,
    output logic [3:0] cambio_pend,
    output logic       ocupado,
    output logic       limpiar,
    output logic       falla
);

    localparam int TMAX0 = (MOTOR_CYCLES > DROP_TIMEOUT) ? MOTOR_CYCLES : DROP_TIMEOUT;
    localparam int TMAX  = (TMAX0 > GAP) ? TMAX0 : GAP;
    localparam int TW    = $clog2(TMAX + 1);

    localparam logic [3:0]    PRICE_A4 = 4'(PRICE_A);
    localparam logic [3:0]    PRICE_B4 = 4'(PRICE_B);
    localparam logic [TW-1:0] T_MOTOR  = TW'(MOTOR_CYCLES);
    localparam logic [TW-1:0] T_DROP   = TW'(DROP_TIMEOUT);
    localparam logic [TW-1:0] T_GAP    = TW'(GAP);

    state_t     state_reg, state_next;
    prod_t      prod_reg, prod_next;
    logic [3:0] credit_reg, credit_next;
    logic [3:0] owed_reg, owed_next;
    logic       drop_reg, drop_next;
    logic [3:0] pend_next;
    logic       falla_next;
    logic       pulso_next;
    logic       limpiar_next;
    logic       motora_next, motorb_next;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;
    logic [3:0]    refund;

    // One timer serves motor run, drop timeout and change gap: never overlapping.
    cycle_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            prod_reg     <= PROD_A;
            credit_reg   <= '0;
            owed_reg     <= '0;
            drop_reg     <= 1'b0;
            motorA       <= 1'b0;
            motorB       <= 1'b0;
            cambio_pulso <= 1'b0;
            cambio_pend  <= '0;
            ocupado      <= 1'b0;
            limpiar      <= 1'b0;
            falla        <= 1'b0;
        end else begin
            state_reg    <= state_next;
            prod_reg     <= prod_next;
            credit_reg   <= credit_next;
            owed_reg     <= owed_next;
            drop_reg     <= drop_next;
            motorA       <= motora_next;
            motorB       <= motorb_next;
            cambio_pulso <= pulso_next;
            cambio_pend  <= pend_next;
            ocupado      <= (state_next != IDLE);
            limpiar      <= limpiar_next;
            falla        <= falla_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        prod_next    = prod_reg;
        credit_next  = credit_reg;
        owed_next    = owed_reg;
        drop_next    = drop_reg;
        pend_next    = cambio_pend;
        falla_next   = falla;
        pulso_next   = 1'b0;
        limpiar_next = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = T_MOTOR;
        refund       = owed_reg;

        unique case (state_reg)
            IDLE: begin
                if (vendA || vendB) begin
                    prod_next   = vendB ? PROD_B : PROD_A;
                    credit_next = total;
                    owed_next   = sub_sat(total, vendB ? PRICE_B4 : PRICE_A4);
                    drop_next   = 1'b0;
                    falla_next  = 1'b0;
                    tmr_load    = 1'b1;
                    tmr_val     = T_MOTOR;
                    state_next  = MOTOR;
                end
            end
            MOTOR: begin
                if (caida) drop_next = 1'b1;
                if (tmr_done) begin
                    tmr_load   = 1'b1;
                    tmr_val    = T_DROP;
                    state_next = DROP;
                end
            end
            DROP: begin
                if (caida) drop_next = 1'b1;
                if (drop_reg || tmr_done) begin
                    // Timeout without a drop refunds the whole credit.
                    if (!drop_reg) begin
                        falla_next = 1'b1;
                        refund     = credit_reg;
                    end
                    if (refund == 4'd0) begin
                        limpiar_next = 1'b1;
                        state_next   = DONE;
                    end else begin
                        pulso_next = 1'b1;
                        pend_next  = refund - 4'd1;
                        tmr_load   = 1'b1;
                        tmr_val    = T_GAP;
                        state_next = CHANGE;
                    end
                end
            end
            CHANGE: begin
                if (tmr_done) begin
                    if (cambio_pend == 4'd0) begin
                        limpiar_next = 1'b1;
                        state_next   = DONE;
                    end else begin
                        pulso_next = 1'b1;
                        pend_next  = cambio_pend - 4'd1;
                        tmr_load   = 1'b1;
                        tmr_val    = T_GAP;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        motora_next = (state_next == MOTOR) && (prod_next == PROD_A);
        motorb_next = (state_next == MOTOR) && (prod_next == PROD_B);
    end

endmodule

// File: tb/tb_vend_dispenser.sv
// Directed bench for vend_dispenser: chained table of vend transactions with
// hand-computed cycle offsets, plus an asynchronous reset in the middle of change.
module tb_vend_dispenser;

    logic       clk;
    logic       reset_n;
    logic       vendA;
    logic       vendB;
    logic [3:0] total;
    logic       caida;
    logic       motorA;
    logic       motorB;
    logic       cambio_pulso;
    logic [3:0] cambio_pend;
    logic       ocupado;
    logic       limpiar;
    logic       falla;

    vend_dispenser dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .vendA        (vendA),
        .vendB        (vendB),
        .total        (total),
        .caida        (caida),
        .motorA       (motorA),
        .motorB       (motorB),
        .cambio_pulso (cambio_pulso),
        .cambio_pend  (cambio_pend),
        .ocupado      (ocupado),
        .limpiar      (limpiar),
        .falla        (falla)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offsets are cycles after the strobe cycle T. caida_at/rs = 0 means none.
    typedef struct {
        logic       va;
        logic       vb;
        logic [3:0] tot;
        int         caida_at;
        int         rs1;
        int         rs2;
        logic       exp_b;      // 1: motorB runs, 0: motorA runs
        int         npulse;
        int         first;      // first change pulse offset
        int         lim;        // limpiar offset
        int         fat;        // falla rise offset, 0 = no fault
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    int passed;
    int total_checks;

    function automatic logic [9:0] pack_out();
        return {motorA, motorB, cambio_pulso, cambio_pend, ocupado, limpiar, falla};
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        total_checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got mA/mB/pul/pend/ocu/lim/fal=%b required %b", name, act, exp);
        end
    endtask

    task automatic strobe(input int i);
        vendA = vecs[i].va;
        vendB = vecs[i].vb;
        total = vecs[i].tot;
    endtask

    // Runs the window T+1 .. T+lim+1; on the last cycle optionally strobes vector nxt.
    task automatic run_vec(input int i, input int nxt);
        vec_t       v;
        logic [9:0] exp;
        int         p;
        logic       e_pul;
        logic [3:0] e_pend;
        v = vecs[i];
        for (int k = 1; k <= v.lim + 1; k++) begin
            @(posedge clk);
            #1;
            vendA = 1'b0;
            vendB = 1'b0;
            total = 4'($urandom_range(0, 15));
            caida = (k == v.caida_at);
            if (k == v.rs1 || k == v.rs2) vendB = 1'b1;
            if (k == v.lim + 1 && nxt >= 0) strobe(nxt);

            e_pul  = 1'b0;
            e_pend = 4'd0;
            if (v.npulse > 0 && k >= v.first) begin
                p = (k - v.first) / 4 + 1;
                if (p > v.npulse) p = v.npulse;
                e_pend = 4'(v.npulse - p);
                e_pul  = ((k - v.first) % 4 == 0) && ((k - v.first) / 4 < v.npulse);
            end
            exp = {(!v.exp_b && k <= 8), (v.exp_b && k <= 8), e_pul, e_pend,
                   (k <= v.lim), (k == v.lim), (v.fat != 0 && k >= v.fat)};
            check($sformatf("v%0d_k%0d", i, k), pack_out(), exp);
        end
    endtask

    initial begin
        passed       = 0;
        total_checks = 0;
        //          va    vb    tot  caida rs1 rs2 exp_b np first lim fat
        vecs[0] = '{1'b1, 1'b0, 4'd5,  4,  0,  0, 1'b0, 3, 10, 22,  0};
        vecs[1] = '{1'b0, 1'b1, 4'd3,  4,  0,  0, 1'b1, 0,  0, 10,  0};
        vecs[2] = '{1'b1, 1'b0, 4'd4,  0,  0,  0, 1'b0, 4, 41, 57, 41};
        vecs[3] = '{1'b1, 1'b1, 4'd6,  2,  0,  0, 1'b1, 3, 10, 22,  0};
        vecs[4] = '{1'b1, 1'b0, 4'd5,  4,  3, 12, 1'b0, 3, 10, 22,  0};
        vecs[5] = '{1'b1, 1'b0, 4'd9, 15,  0,  0, 1'b0, 7, 17, 45,  0};
        vecs[6] = '{1'b1, 1'b0, 4'd1,  9,  0,  0, 1'b0, 0,  0, 11,  0};
        vecs[7] = '{1'b0, 1'b1, 4'd0, 20,  0,  0, 1'b1, 0,  0, 22,  0};

        reset_n = 1'b0;
        vendA   = 1'b0;
        vendB   = 1'b0;
        total   = 4'd0;
        caida   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", pack_out(), 10'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // A caida pulse while idle must not leak into the next vend.
        @(posedge clk);
        #1;
        caida = 1'b1;
        @(posedge clk);
        #1;
        caida = 1'b0;
        check("idle_caida", pack_out(), 10'b0);

        // Back-to-back transactions: each next strobe lands in the first idle cycle.
        strobe(0);
        for (int i = 0; i < NV; i++) begin
            run_vec(i, (i < NV - 1) ? i + 1 : -1);
        end

        // Asynchronous reset in the middle of change with two units still owed.
        @(posedge clk);
        #1;
        strobe(0);
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            #1;
            vendA = 1'b0;
            vendB = 1'b0;
            caida = (k == 4);
            if (k == 10) check("pre_reset_pulse", pack_out(), 10'b0010010100);
        end
        #2;
        check("pre_reset_pend", pack_out(), 10'b0000010100);
        reset_n = 1'b0;
        #1;
        check("async_reset", pack_out(), 10'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_idle", pack_out(), 10'b0);
        strobe(0);
        run_vec(0, -1);

        $display("%0d/%0d checks passed", passed, total_checks);
        $finish;
    end

endmodule
